// File: rtl/pulse_catcher_if.sv
// pulse_catcher_if: request/flag bundle between fast peripherals, the pulse
// catcher and the slow-domain sampler.
//   in       : fast-domain request per channel (level or pulse)
//   slowClk  : slow-domain clock, carried as plain data
//   out      : stretched flag per channel
//   overflow : sticky per-channel "event dropped" flag
// Modports: master drives requests and slowClk, slave (the catcher) drives
// out/overflow.
interface pulse_catcher_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] in;
    logic                slowClk;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] overflow;

    modport master (
        output in,
        output slowClk,
        input  out,
        input  overflow
    );

    modport slave (
        input  in,
        input  slowClk,
        output out,
        output overflow
    );
endinterface

// File: rtl/pulse_catcher.sv
// pulse_catcher: stretches short fast-domain requests into flags that stay
// high until the slow domain has seen them on a rising slowClk edge.
// Everything runs on clk; slowClk is only sampled through a synchroniser.
//   clk      : fast clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : pulse_catcher_if.slave (in, slowClk -> out, overflow)
// Optional macro PULSE_CATCHER_COUNT_EN: per-channel pending counters queue
// back-to-back rises as separate slow-visible pulses, separated by a GAP
// phase; overflow flags a rise dropped at a saturated counter. Without it,
// rises while busy merge into the current event and overflow is 0.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no event, out=0
// WAIT_LOW  | flag raised, waiting for synchronised slowClk low
// WAIT_HIGH | flag raised, waiting for synchronised slowClk high
// DONE      | slow domain sampled the flag; hold while request stays high
// GAP       | flag low for one full slowClk low->high before next queued event
module pulse_catcher #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    pulse_catcher_if.slave  bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_LOW  = 3'd1;
    localparam logic [2:0] S_WAIT_HIGH = 3'd2;
    localparam logic [2:0] S_DONE      = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    if (SYNC_STAGES < 2 || CNT_WIDTH < 1) begin : g_param_check
        $error("pulse_catcher: SYNC_STAGES must be >= 2 and CNT_WIDTH >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   slow_s;
    logic [CHANNELS-1:0]    in_q;
    logic [CHANNELS-1:0]    rise;
    logic [CHANNELS-1:0]    out_q;
    logic [CHANNELS-1:0]    out_d;
    logic [2:0]             state_q [CHANNELS];
    logic [2:0]             state_d [CHANNELS];

    assign slow_s = sync_q[SYNC_STAGES-1];
    assign rise   = bus.in & ~in_q;

`ifdef PULSE_CATCHER_COUNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
    logic [CHANNELS-1:0]  seen_low_q;
    logic [CHANNELS-1:0]  seen_low_d;
    logic [CHANNELS-1:0]  ovf_q;
    logic [CHANNELS-1:0]  ovf_d;
`endif

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            // out is a registered copy of the current state's decode, so it
            // lags the state by one cycle on both rise and fall.
            out_d[i]   = (state_q[i] != S_IDLE) && (state_q[i] != S_GAP);
`ifdef PULSE_CATCHER_COUNT_EN
            cnt_d[i]      = cnt_q[i];
            seen_low_d[i] = seen_low_q[i];
            ovf_d[i]      = ovf_q[i];
`endif
            case (state_q[i])
                S_IDLE: begin
                    if (bus.in[i]) state_d[i] = S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!slow_s) state_d[i] = S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    if (slow_s) state_d[i] = S_DONE;
                end
                S_DONE: begin
                    if (!bus.in[i]) begin
`ifdef PULSE_CATCHER_COUNT_EN
                        if (cnt_q[i] != '0) begin
                            state_d[i] = S_GAP;
                            cnt_d[i]   = cnt_q[i] - CNT_ONE;
                        end else begin
                            state_d[i] = S_IDLE;
                        end
`else
                        state_d[i] = S_IDLE;
`endif
                    end
                end
`ifdef PULSE_CATCHER_COUNT_EN
                S_GAP: begin
                    if (!seen_low_q[i]) begin
                        if (!slow_s) seen_low_d[i] = 1'b1;
                    end else if (slow_s) begin
                        seen_low_d[i] = 1'b0;
                        state_d[i]    = S_WAIT_LOW;
                    end
                end
`endif
                default: state_d[i] = S_IDLE;
            endcase
`ifdef PULSE_CATCHER_COUNT_EN
            // A rise in IDLE is the event itself; only rises while busy queue.
            if (rise[i] && (state_q[i] != S_IDLE)) begin
                if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
                else                     cnt_d[i] = cnt_d[i] + CNT_ONE;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            in_q   <= '0;
            out_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) state_q[i] <= S_IDLE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.slowClk};
            in_q   <= bus.in;
            out_q  <= out_d;
            for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
        end
    end

`ifdef PULSE_CATCHER_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_low_q <= '0;
            ovf_q      <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else begin
            seen_low_q <= seen_low_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = '0;
`endif

    assign bus.out = out_q;

endmodule

// File: tb/tb_pulse_catcher.sv
// Directed bench for pulse_catcher (CHANNELS=4, CNT_WIDTH=2, SYNC_STAGES=2).
// clk 10 ns, slowClk 200 ns free-running. Inputs are driven and outputs
// sampled on the falling clk edge; a slow-domain sampler records out on
// every rising slowClk edge.
module tb_pulse_catcher;

`ifdef PULSE_CATCHER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk      = 1'b0;
    logic slow_clk = 1'b0;
    logic reset_n;

    int n_chk  = 0;
    int n_fail = 0;
    int nsmp   = 0;
    int s0;
    logic [3:0] smp [0:127];

    pulse_catcher_if #(.CHANNELS(4)) bus ();

    assign bus.slowClk = slow_clk;

    pulse_catcher #(
        .CHANNELS   (4),
        .CNT_WIDTH  (2),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5   clk      = ~clk;
    always #100 slow_clk = ~slow_clk;

    always @(posedge slow_clk) begin
        if (nsmp < 128) smp[nsmp] = bus.out;
        nsmp++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Lands 10 ns after a rising slowClk edge, after that edge's sample.
    task automatic align();
        @(posedge slow_clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] seq(input int ch, input int start, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k] = smp[start + k][ch];
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        bus.in  = '0;

        // Reset held while requests toggle.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_out", 32'(bus.out), 'h0);
            chk("rst_ovf", 32'(bus.overflow), 'h0);
            bus.in = (i % 2 == 0) ? 4'hF : 4'h0;
        end
        bus.in  = '0;
        reset_n = 1'b1;
        tick(1);
        bus.in = 4'b0001;
        tick(1);
        chk("rst_lat0", 32'(bus.out), 'h0);
        bus.in = '0;
        tick(1);
        chk("rst_lat1", 32'(bus.out), 'h1);
        tick(60);
        chk("rst_done", 32'(bus.out), 'h0);

        // Single one-cycle pulse on channel 1.
        align();
        s0 = nsmp;
        bus.in = 4'b0010;
        tick(1);
        chk("sp_lat0", 32'(bus.out), 'h0);
        bus.in = '0;
        tick(1);
        chk("sp_lat1", 32'(bus.out), 'h2);
        tick(21);
        chk("sp_hold", 32'(bus.out), 'h2);
        tick(1);
        chk("sp_fall", 32'(bus.out), 'h0);
        tick(20);
        chk("sp_seq", seq(1, s0, 2), 'h1);

        // Level held for 1 us on channel 2.
        align();
        bus.in = 4'b0100;
        tick(49);
        chk("hl_mid", 32'(bus.out), 'h4);
        tick(50);
        chk("hl_late", 32'(bus.out), 'h4);
        tick(1);
        bus.in = '0;
        tick(1);
        chk("hl_lag", 32'(bus.out), 'h4);
        tick(1);
        chk("hl_fall", 32'(bus.out), 'h0);

        // Three pulses 30 ns apart on channel 0.
        align();
        s0 = nsmp;
        for (int k = 0; k < 3; k++) begin
            bus.in = 4'b0001;
            tick(1);
            bus.in = '0;
            if (k < 2) tick(2);
        end
        tick(16);
        chk("q_first_hold", 32'(bus.out), 'h1);
        tick(1);
        chk("q_first_fall", 32'(bus.out), 'h0);
        tick(19);
        chk("q_second", 32'(bus.out), CNT_EN ? 'h1 : 'h0);
        tick(77);
        chk("q_seq", seq(0, s0, 6), CNT_EN ? 'h15 : 'h01);
        chk("q_ovf", 32'(bus.overflow), 'h0);

        // Five pulses within one slow period on channel 3.
        align();
        s0 = nsmp;
        for (int k = 0; k < 5; k++) begin
            chk("ov_pre", 32'(bus.overflow), 'h0);
            bus.in = 4'b1000;
            tick(1);
            bus.in = '0;
            tick(2);
        end
        chk("ov_set", 32'(bus.overflow), CNT_EN ? 'h8 : 'h0);
        tick(145);
        chk("ov_seq", seq(3, s0, 8), CNT_EN ? 'h55 : 'h01);
        chk("ov_sticky", 32'(bus.overflow), CNT_EN ? 'h8 : 'h0);
        chk("ov_idle", 32'(bus.out), 'h0);

        // Reset while channel 0 waits for slowClk high, with one queued rise.
        align();
        s0 = nsmp;
        bus.in = 4'b0001;
        tick(1);
        bus.in = '0;
        tick(2);
        bus.in = 4'b0001;
        tick(1);
        bus.in = '0;
        tick(10);
        chk("mr_busy", 32'(bus.out), 'h1);
        reset_n = 1'b0;
        #1;
        chk("mr_drop", 32'(bus.out), 'h0);
        chk("mr_ovf", 32'(bus.overflow), 'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(29);
        chk("mr_seq", seq(0, s0, 2), 'h0);
        chk("mr_out", 32'(bus.out), 'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
